ni_flit_retx_buffer: RTL

//  Go-back-N retransmission buffer between an NI packetizer (flit/valid/full) and the NoC output link.

---
 rtl/ni_flit_retx_buffer_if.sv | 42 ++++
 rtl/ni_flit_retx_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ni_flit_retx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_flit_retx_buffer_if
// Description : Bundle of packetizer-side and link-side signals for the
//               go-back-N flit retransmission buffer.
//                 data_in   - flit from packetizer
//                 write     - push data_in (ignored while full)
//                 full      - buffer holds DEPTH unACKed/unsent flits
//                 empty     - nothing stored, nothing awaiting ACK
//                 FLIT_out  - flit on the link (valid with VALID_out)
//                 VALID_out - FLIT_out transmitted this cycle
//                 ACK_in    - oldest in-flight transmission accepted
//                 NACK_in   - oldest in-flight transmission rejected
//                 proto_err - sticky protocol-violation flag
//               master : packetizer + link side (drives data/responses)
//               slave  : the retransmission buffer
// Revision    : 1.0 - initial release
// ============================================================================
interface ni_flit_retx_buffer_if #(
    parameter int FLIT_WIDTH = 80
);
    logic [FLIT_WIDTH-1:0] data_in;
    logic                  write;
    logic                  full;
    logic                  empty;
    logic [FLIT_WIDTH-1:0] FLIT_out;
    logic                  VALID_out;
    logic                  ACK_in;
    logic                  NACK_in;
    logic                  proto_err;

    modport master (
        output data_in, write, ACK_in, NACK_in,
        input  full, empty, FLIT_out, VALID_out, proto_err
    );

    modport slave (
        input  data_in, write, ACK_in, NACK_in,
        output full, empty, FLIT_out, VALID_out, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/ni_flit_retx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ni_flit_retx_buffer
// Description : Go-back-N retransmission buffer between an NI packetizer and
//               a NoC output link. Accepted flits are kept until the link
//               ACKs them. On a NACK the buffer stops sending, waits for all
//               outstanding responses, then resends from the oldest unACKed
//               flit.
// Ports       : clk  - NoC clock, rising edge
//               rst  - asynchronous, active-low reset
//               bus  - ni_flit_retx_buffer_if.slave (data_in, write, full,
//                      empty, FLIT_out, VALID_out, ACK_in, NACK_in,
//                      proto_err)
// Revision    : 1.0 - initial release
// ============================================================================
module ni_flit_retx_buffer #(
    parameter int FLIT_WIDTH = 80,
    parameter int DEPTH      = 8,
    parameter int LOG_DEPTH  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ni_flit_retx_buffer_if.slave  bus
);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    localparam int                  c_PTR_W = LOG_DEPTH + 1;
    localparam logic [c_PTR_W-1:0]  c_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]  c_ZERO  = '0;

    typedef enum logic [0:0] {
        ST_SEND  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_send_ptr;
    logic [c_PTR_W-1:0]    r_ack_ptr;
    logic [c_PTR_W-1:0]    r_inflight;
    state_t                r_state;
    logic                  r_proto_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]    w_occupancy;
    logic [c_PTR_W-1:0]    w_pending;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_send;
    logic                  w_resp_any;
    logic                  w_resp_ok;
    logic                  w_nack;
    logic                  w_err;
    logic [c_PTR_W-1:0]    w_inflight_next;
    logic [c_PTR_W-1:0]    w_send_ptr_next;
    logic [c_PTR_W-1:0]    w_ack_ptr_next;
    state_t                w_state_next;

    assign w_occupancy = r_wr_ptr - r_ack_ptr;
    assign w_pending   = r_wr_ptr - r_send_ptr;
    assign w_full      = (w_occupancy == c_DEPTH);
    assign w_empty     = (w_occupancy == c_ZERO);
    assign w_wr_en     = bus.write && !w_full;

    // The link never stalls, so a flit leaves whenever there is something
    // unsent and the response window is not exhausted.
    assign w_send      = (r_state == ST_SEND) && (w_pending != c_ZERO) &&
                         (r_inflight < c_DEPTH);

    // A response is only meaningful if something is in flight. A flit sent
    // this cycle cannot be answered in the same cycle.
    assign w_resp_any  = bus.ACK_in || bus.NACK_in;
    assign w_resp_ok   = w_resp_any && (r_inflight != c_ZERO);
    // Simultaneous ACK and NACK is resolved conservatively as NACK.
    assign w_nack      = bus.NACK_in;
    assign w_err       = (bus.ACK_in && bus.NACK_in) ||
                         (w_resp_any && (r_inflight == c_ZERO));

    assign w_inflight_next = r_inflight
                           + (w_send    ? c_ONE : c_ZERO)
                           - (w_resp_ok ? c_ONE : c_ZERO);

    // ------------------------------------------------------------------
    // Next-state / pointer logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_send_ptr_next = r_send_ptr + (w_send ? c_ONE : c_ZERO);
        w_ack_ptr_next  = r_ack_ptr;

        case (r_state)
            ST_SEND: begin
                if (w_resp_ok) begin
                    if (w_nack) begin
                        // If the NACK was the last outstanding response
                        // there is nothing to drain: rewind immediately.
                        if (w_inflight_next == c_ZERO) begin
                            w_send_ptr_next = r_ack_ptr;
                        end else begin
                            w_state_next = ST_DRAIN;
                        end
                    end else begin
                        w_ack_ptr_next = r_ack_ptr + c_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Responses here belong to flits sent after the rejected
                // one; they are all discarded and resent, so ack_ptr holds.
                if (w_inflight_next == c_ZERO) begin
                    w_send_ptr_next = r_ack_ptr;
                    w_state_next    = ST_SEND;
                end
            end
            default: begin
                w_state_next = ST_SEND;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SEND;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= c_ZERO;
            r_send_ptr  <= c_ZERO;
            r_ack_ptr   <= c_ZERO;
            r_inflight  <= c_ZERO;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            r_send_ptr  <= w_send_ptr_next;
            r_ack_ptr   <= w_ack_ptr_next;
            r_inflight  <= w_inflight_next;
            r_proto_err <= r_proto_err | w_err;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.VALID_out = w_send;
    assign bus.FLIT_out  = r_mem[r_send_ptr[LOG_DEPTH-1:0]];
    assign bus.proto_err = r_proto_err;

endmodule
`default_nettype wire
